// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// pc_sequencer : program counter, req/ack fetch sequencing, return stack
// Revision     : 1.0
// ============================================================================
module pc_sequencer #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          STACK_DEPTH = 4,
  parameter int          STACK_AW    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_i,
  output logic        imem_req_o,
  output logic [15:0] imem_addr_o,
  input  logic        imem_ack_i,
  output logic        instr_valid_o,
  input  logic        jump_en_i,
  input  logic [11:0] jump_addr_i,
  input  logic        call_en_i,
  input  logic        ret_en_i,
  input  logic        halt_en_i,
  output logic [15:0] pc_o,
  output logic        halted_o,
  output logic        stack_ovf_o,
  output logic        stack_unf_o
);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_fetch  = 2'd1;
  localparam logic [1:0] c_decode = 2'd2;
  localparam logic [1:0] c_halt   = 2'd3;

  localparam logic [STACK_AW:0]   c_sp_one  = {{STACK_AW{1'b0}}, 1'b1};
  localparam logic [STACK_AW:0]   c_sp_full = (STACK_AW + 1)'(STACK_DEPTH);
  localparam logic [STACK_AW-1:0] c_idx_one = {{(STACK_AW - 1){1'b0}}, 1'b1};

  logic [1:0]          state_q, state_d;
  logic [15:0]         pc_q, pc_d;
  logic [STACK_AW:0]   sp_q, sp_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic [15:0]         stack_q [STACK_DEPTH];

  logic                w_decode;
  logic                w_take_ret, w_take_call, w_take_jump, w_take_seq;
  logic                w_full, w_empty;
  logic                w_ovf_hit, w_unf_hit;
  logic                w_push, w_pop;
  logic [STACK_AW-1:0] w_sp_lo, w_top_idx;
  logic [15:0]         w_top, w_pc_inc, w_jump_pc;

  // Decoder strobes only count in DECODE; priority halt > ret > call > jump > seq.
  assign w_decode    = (state_q == c_decode);
  assign w_take_ret  = !halt_en_i && ret_en_i;
  assign w_take_call = !halt_en_i && !ret_en_i && call_en_i;
  assign w_take_jump = !halt_en_i && !ret_en_i && !call_en_i && jump_en_i;
  assign w_take_seq  = !halt_en_i && !ret_en_i && !call_en_i && !jump_en_i;

  assign w_full    = (sp_q == c_sp_full);
  assign w_empty   = (sp_q == '0);
  assign w_unf_hit = w_decode && w_take_ret && w_empty;
  assign w_ovf_hit = w_decode && w_take_call && w_full;
  assign w_pop     = w_decode && w_take_ret && !w_empty;
  assign w_push    = w_decode && w_take_call && !w_full;

  assign w_sp_lo   = sp_q[STACK_AW-1:0];
  assign w_top_idx = w_sp_lo - c_idx_one;
  assign w_top     = stack_q[w_top_idx];
  assign w_pc_inc  = pc_q + 16'd1;
  assign w_jump_pc = {pc_q[15:12], jump_addr_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_idle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_idle:   if (run_i) state_d = c_fetch;
      c_fetch:  if (imem_ack_i) state_d = c_decode;
      c_decode: begin
        if (halt_en_i || w_unf_hit || w_ovf_hit) begin
          state_d = c_halt;
        end else begin
          state_d = c_fetch;
        end
      end
      c_halt:   state_d = c_halt;
      default:  state_d = c_idle;
    endcase
  end

  always_comb begin
    imem_req_o    = (state_q == c_fetch);
    instr_valid_o = (state_q == c_decode);
    halted_o      = (state_q == c_halt);
  end

  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign stack_ovf_o = ovf_q;
  assign stack_unf_o = unf_q;

  // Faulting ret/call leave pc untouched so the halted PC points at the culprit.
  always_comb begin
    pc_d  = pc_q;
    sp_d  = sp_q;
    ovf_d = ovf_q | w_ovf_hit;
    unf_d = unf_q | w_unf_hit;
    if (w_decode) begin
      if (w_pop) begin
        pc_d = w_top;
        sp_d = sp_q - c_sp_one;
      end else if (w_push) begin
        pc_d = w_jump_pc;
        sp_d = sp_q + c_sp_one;
      end else if (w_take_jump) begin
        pc_d = w_jump_pc;
      end else if (w_take_seq) begin
        pc_d = w_pc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else if (w_push) begin
      stack_q[w_sp_lo] <= w_pc_inc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// tb_pc_sequencer : randomized self-checking bench with instruction-level model
// Revision        : 1.0
// ============================================================================
module tb_pc_sequencer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0, ack = 1'b0;
  logic        jen = 1'b0, cen = 1'b0, ren = 1'b0, hen = 1'b0;
  logic [11:0] jaddr = 12'h000;
  logic        imem_req, instr_valid, halted, ovf, unf;
  logic [15:0] imem_addr, pc;

  int n_total = 0;
  int n_bad   = 0;

  logic [15:0] m_pc;
  logic [15:0] m_stack[$];
  bit          m_ovf, m_unf, m_halt;

  pc_sequencer #(.RESET_PC(16'h0000), .STACK_DEPTH(DEPTH), .STACK_AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .run_i(run),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ack_i(ack),
    .instr_valid_o(instr_valid),
    .jump_en_i(jen), .jump_addr_i(jaddr), .call_en_i(cen), .ret_en_i(ren),
    .halt_en_i(hen), .pc_o(pc), .halted_o(halted),
    .stack_ovf_o(ovf), .stack_unf_o(unf)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 16'h0000;
    m_stack.delete();
    m_ovf = 0; m_unf = 0; m_halt = 0;
  endtask

  // One retired instruction, straight from the next-PC rules.
  task automatic model_instr(input bit h, r, c, j, input logic [11:0] a);
    if (h) m_halt = 1;
    else if (r) begin
      if (m_stack.size() == 0) begin m_unf = 1; m_halt = 1; end
      else m_pc = m_stack.pop_back();
    end else if (c) begin
      if (m_stack.size() == DEPTH) begin m_ovf = 1; m_halt = 1; end
      else begin
        m_stack.push_back(m_pc + 16'd1);
        m_pc = {m_pc[15:12], a};
      end
    end else if (j) m_pc = {m_pc[15:12], a};
    else m_pc = m_pc + 16'd1;
  endtask

  task automatic clear_strobes();
    hen = 0; ren = 0; cen = 0; jen = 0; jaddr = 12'h000;
  endtask

  task automatic junk_strobes();
    hen = 1'($urandom); ren = 1'($urandom); cen = 1'($urandom);
    jen = 1'($urandom); jaddr = 12'($urandom);
  endtask

  // Reset, then pulse run; leaves the DUT in its first fetch.
  task automatic start();
    @(posedge clk); #1;
    run = 0; ack = 0; clear_strobes();
    rst_n = 0; #2; rst_n = 1;
    model_reset();
    @(posedge clk); #1; run = 1;
    @(posedge clk); #1; run = 0;
  endtask

  // Drives one fetch (with ack delay) and one decode; reports protocol observations.
  task automatic exec_instr(input bit h, r, c, j, input logic [11:0] a,
                            input int delay, input bit junk,
                            output bit stable, output bit v_dec, output bit v_after);
    logic [15:0] addr0;
    addr0  = imem_addr;
    stable = imem_req;
    for (int k = 0; k < delay; k++) begin
      ack = 0;
      if (junk) junk_strobes();
      @(posedge clk); #1;
      if (!(imem_req === 1'b1 && imem_addr === addr0)) stable = 0;
    end
    ack = 1;
    @(posedge clk); #1;
    ack = junk ? 1'($urandom) : 1'b0;
    v_dec = instr_valid;
    hen = h; ren = r; cen = c; jen = j; jaddr = a;
    @(posedge clk); #1;
    ack = 0;
    v_after = instr_valid;
    clear_strobes();
    model_instr(h, r, c, j, a);
  endtask

  task automatic goto_page(input logic [3:0] pg);
    bit s, v, va;
    for (int n = 0; n < 20 && m_pc[15:12] != pg; n++) begin
      exec_instr(0, 0, 0, 1, 12'hFFF, 0, 0, s, v, va);
      exec_instr(0, 0, 0, 0, 12'h000, 0, 0, s, v, va);
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst_n = 0; #1;
    n_total++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_total++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    n_total++; if (halted !== 1'b0) begin n_bad++; $display("FAIL rst_halted: got %b want 0", halted); end
    n_total++; if (pc !== 16'h0000) begin n_bad++; $display("FAIL rst_pc: got %h want 0000", pc); end
    n_total++; if ({ovf, unf} !== 2'b00) begin n_bad++; $display("FAIL rst_err: got %b want 00", {ovf, unf}); end
    rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL idle_req: got %b want 0", imem_req); end
    run = 1; @(posedge clk); #1; run = 0;
    n_total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      n_bad++; $display("FAIL run_fetch: got req=%b addr=%h want req=1 addr=0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    bit s, v, va;
    start();
    for (int i = 0; i < 4; i++) begin
      n_total++; if (pc !== m_pc) begin n_bad++; $display("FAIL seq_pc%0d: got %h want %h", i, pc, m_pc); end
      exec_instr(0, 0, 0, 0, 12'h000, 0, 0, s, v, va);
      n_total++; if (v !== 1'b1 || va !== 1'b0) begin
        n_bad++; $display("FAIL seq_valid%0d: got %b%b want 10", i, v, va);
      end
    end
  endtask

  task automatic test_jump();
    bit s, v, va;
    start();
    goto_page(4'h3);
    exec_instr(0, 0, 0, 1, 12'h005, 0, 0, s, v, va);
    n_total++; if (pc !== 16'h3005) begin n_bad++; $display("FAIL jump_setup: got %h want 3005", pc); end
    exec_instr(0, 0, 0, 1, 12'hAAA, 0, 0, s, v, va);
    n_total++; if (pc !== 16'h3AAA || imem_addr !== 16'h3AAA || imem_req !== 1'b1) begin
      n_bad++; $display("FAIL jump_pc: got pc=%h addr=%h req=%b want 3AAA 3AAA 1", pc, imem_addr, imem_req);
    end
  endtask

  task automatic test_call_ret();
    bit s, v, va;
    start();
    exec_instr(0, 0, 0, 1, 12'h010, 0, 0, s, v, va);
    exec_instr(0, 0, 1, 0, 12'h200, 0, 0, s, v, va);
    n_total++; if (pc !== 16'h0200) begin n_bad++; $display("FAIL call_pc: got %h want 0200", pc); end
    exec_instr(0, 1, 0, 0, 12'h000, 0, 0, s, v, va);
    n_total++; if (pc !== 16'h0011) begin n_bad++; $display("FAIL ret_pc: got %h want 0011", pc); end
  endtask

  task automatic test_overflow();
    bit s, v, va;
    logic [15:0] frozen;
    start();
    for (int i = 0; i < DEPTH; i++) exec_instr(0, 0, 1, 0, 12'($urandom), 0, 0, s, v, va);
    n_total++; if (halted !== 1'b0 || pc !== m_pc) begin
      n_bad++; $display("FAIL nest_calls: got halted=%b pc=%h want 0 %h", halted, pc, m_pc);
    end
    frozen = m_pc;
    exec_instr(0, 0, 1, 0, 12'h777, 0, 0, s, v, va);
    n_total++; if (ovf !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0 || pc !== frozen) begin
      n_bad++; $display("FAIL ovf: got ovf=%b halted=%b req=%b pc=%h want 1 1 0 %h", ovf, halted, imem_req, pc, frozen);
    end
    for (int i = 0; i < 4; i++) begin
      run = 1; ack = 1; junk_strobes();
      @(posedge clk); #1;
      n_total++; if (halted !== 1'b1 || pc !== frozen || imem_req !== 1'b0) begin
        n_bad++; $display("FAIL halt_hold%0d: got halted=%b pc=%h req=%b", i, halted, pc, imem_req);
      end
    end
    run = 0; ack = 0; clear_strobes();
    #2; rst_n = 0; #1;
    n_total++; if ({ovf, unf, halted} !== 3'b000 || pc !== 16'h0000) begin
      n_bad++; $display("FAIL ovf_clear: got err=%b%b halted=%b pc=%h want 000 0000", ovf, unf, halted, pc);
    end
    rst_n = 1;
  endtask

  task automatic test_underflow();
    bit s, v, va;
    start();
    exec_instr(0, 1, 0, 0, 12'h000, 0, 0, s, v, va);
    n_total++; if (unf !== 1'b1 || halted !== 1'b1 || ovf !== 1'b0 || pc !== 16'h0000) begin
      n_bad++; $display("FAIL unf: got unf=%b halted=%b ovf=%b pc=%h want 1 1 0 0000", unf, halted, ovf, pc);
    end
  endtask

  task automatic test_ack_stall();
    bit s, v, va;
    start();
    exec_instr(0, 0, 0, 0, 12'h000, 0, 0, s, v, va);
    exec_instr(0, 0, 0, 0, 12'h000, 5, 1, s, v, va);
    n_total++; if (s !== 1'b1) begin n_bad++; $display("FAIL stall_stable: got %b want 1", s); end
    n_total++; if (v !== 1'b1 || va !== 1'b0 || pc !== 16'h0002) begin
      n_bad++; $display("FAIL stall_decode: got v=%b%b pc=%h want 10 0002", v, va, pc);
    end
    goto_page(4'hF);
    exec_instr(0, 0, 0, 1, 12'hFFF, 0, 0, s, v, va);
    n_total++; if (pc !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_setup: got %h want FFFF", pc); end
    exec_instr(0, 0, 0, 0, 12'h000, 0, 0, s, v, va);
    n_total++; if (pc !== 16'h0000) begin n_bad++; $display("FAIL wrap_pc: got %h want 0000", pc); end
  endtask

  task automatic test_async_reset();
    bit s, v, va;
    start();
    exec_instr(0, 0, 0, 1, 12'h123, 0, 0, s, v, va);
    ack = 0;
    @(posedge clk); #3;
    rst_n = 0; #1;
    n_total++; if (imem_req !== 1'b0 || pc !== 16'h0000) begin
      n_bad++; $display("FAIL async_rst: got req=%b pc=%h want 0 0000", imem_req, pc);
    end
    rst_n = 1;
    model_reset();
    @(posedge clk); #1;
    n_total++; if (imem_req !== 1'b0 || halted !== 1'b0) begin
      n_bad++; $display("FAIL async_idle: got req=%b halted=%b want 0 0", imem_req, halted);
    end
  endtask

  task automatic test_priority();
    bit s, v, va;
    start();
    exec_instr(0, 0, 0, 1, 12'h040, 0, 0, s, v, va);
    exec_instr(1, 0, 0, 1, 12'hABC, 0, 0, s, v, va);
    n_total++; if (halted !== 1'b1 || pc !== 16'h0040 || imem_req !== 1'b0) begin
      n_bad++; $display("FAIL halt_jump: got halted=%b pc=%h req=%b want 1 0040 0", halted, pc, imem_req);
    end
    start();
    exec_instr(0, 0, 1, 0, 12'h100, 0, 0, s, v, va);
    exec_instr(0, 1, 1, 0, 12'h222, 0, 0, s, v, va);
    n_total++; if (pc !== 16'h0001 || halted !== 1'b0) begin
      n_bad++; $display("FAIL call_ret_same: got pc=%h halted=%b want 0001 0", pc, halted);
    end
    exec_instr(0, 1, 0, 0, 12'h000, 0, 0, s, v, va);
    n_total++; if (unf !== 1'b1 || halted !== 1'b1) begin
      n_bad++; $display("FAIL ret_after_pair: got unf=%b halted=%b want 1 1", unf, halted);
    end
  endtask

  task automatic test_random();
    bit s, v, va, h, r, c, j;
    for (int round = 0; round < 8; round++) begin
      start();
      for (int k = 0; k < 40 && !m_halt; k++) begin
        h = ($urandom_range(0, 29) == 0);
        r = ($urandom_range(0, 3) == 0);
        c = ($urandom_range(0, 2) == 0);
        j = 1'($urandom);
        exec_instr(h, r, c, j, 12'($urandom), int'($urandom_range(0, 3)), 1, s, v, va);
        n_total++; if (pc !== m_pc || halted !== m_halt || ovf !== m_ovf || unf !== m_unf) begin
          n_bad++;
          $display("FAIL rnd_state r%0d i%0d: got pc=%h h=%b o=%b u=%b want pc=%h h=%b o=%b u=%b",
                   round, k, pc, halted, ovf, unf, m_pc, m_halt, m_ovf, m_unf);
        end
        n_total++; if (imem_req !== !m_halt || imem_addr !== m_pc || s !== 1'b1 || v !== 1'b1) begin
          n_bad++;
          $display("FAIL rnd_proto r%0d i%0d: got req=%b addr=%h stable=%b valid=%b want req=%b addr=%h 1 1",
                   round, k, imem_req, imem_addr, s, v, !m_halt, m_pc);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_jump();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_ack_stall();
    test_async_reset();
    test_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
